// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// The FSM state encoding and the default operand width live here.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  localparam int SA_DEFAULT_WIDTH = 8;

endpackage : serial_adder_pkg

// File: rtl/full_adder_dataflow.sv
// Single-bit full adder, pure dataflow.
// This is the one arithmetic cell that the serial adder reuses every cycle.
module full_adder_dataflow (
  output logic sum,
  output logic carry_out,
  input  logic a,
  input  logic b,
  input  logic carry_in
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule : full_adder_dataflow

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, a carry flop and operand shift registers.
// It adds LSB first and presents {carry_out, sum_out} one cycle after the last bit (done pulse).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  sa_state_t        r_state;
  sa_state_t        w_next_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum_out;
  logic             r_carry_out;
  logic             r_c_ff;
  logic [CW-1:0]    r_cnt;
  logic             w_fa_sum;
  logic             w_fa_cout;
  logic             w_load;
  logic             w_last;
  logic             w_busy;
  logic             w_done;

  full_adder_dataflow u_fa (w_fa_sum, w_fa_cout, r_a_sh[0], r_b_sh[0], r_c_ff);

  // A new request is only accepted when no operation is in flight.
  assign w_load = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last = (r_state == RUN) && (r_cnt == LAST_CNT);

  // Next-state decode plus the busy/done flags, which are pure decodes of the state register.
  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = RUN;
        end else begin
          w_next_state = IDLE;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_next_state = DONE;
        end else begin
          w_next_state = RUN;
        end
      end
      DONE: begin
        w_done = 1'b1;
        if (start) begin
          w_next_state = RUN;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register and serial datapath; reset aborts any operation and clears the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_acc       <= '0;
      r_c_ff      <= 1'b0;
      r_cnt       <= '0;
      r_sum_out   <= '0;
      r_carry_out <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_a_sh <= a_in;
        r_b_sh <= b_in;
        r_c_ff <= carry_in;
        r_acc  <= '0;
        r_cnt  <= '0;
      end else if (r_state == RUN) begin
        r_acc  <= {w_fa_sum, r_acc[WIDTH-1:1]};
        r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
        r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
        r_c_ff <= w_fa_cout;
        // Wrap to zero on the last bit so the counter never leaves 0..WIDTH-1.
        if (w_last) begin
          r_cnt       <= '0;
          r_sum_out   <= {w_fa_sum, r_acc[WIDTH-1:1]};
          r_carry_out <= w_fa_cout;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign busy      = w_busy;
  assign done      = w_done;
  assign sum_out   = r_sum_out;
  assign carry_out = r_carry_out;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): latency, handshake, reset abort and arithmetic.
// Expected sums are hand-computed constants, plus a+b+cin evaluated by the bench for random operands.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         carry_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         carry_out;

  int checks;
  int failures;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .sum_out   (sum_out),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts one operation and waits for done; leaves the bench inside the DONE cycle.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic [W-1:0] exp_sum, input logic exp_cout,
                        input logic poke);
    int lat;
    int busy_n;
    logic both;
    start    = 1'b1;
    a_in     = a;
    b_in     = b;
    carry_in = cin;
    tick();
    start    = 1'b0;
    a_in     = 8'h00;
    b_in     = 8'h00;
    carry_in = 1'b0;
    lat    = 1;
    busy_n = 0;
    both   = 1'b0;
    while (done !== 1'b1 && lat < 30) begin
      if (busy === 1'b1) busy_n++;
      if (busy === 1'b1 && done === 1'b1) both = 1'b1;
      if (poke && lat == 3) begin
        start    = 1'b1;
        a_in     = 8'h11;
        b_in     = 8'h22;
        carry_in = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, lat, 9);
    chk({tag, "_busy_cycles"}, busy_n, 8);
    chk({tag, "_busy_done_overlap"}, {31'd0, both}, 32'd0);
    chk({tag, "_sum"}, {24'd0, sum_out}, {24'd0, exp_sum});
    chk({tag, "_cout"}, {31'd0, carry_out}, {31'd0, exp_cout});
  endtask

  // One cycle after DONE with no start: done must have dropped and the adder be idle.
  task automatic check_idle(input string tag);
    tick();
    chk({tag, "_done_width"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic [W:0]   rexp;
    int           done_seen;

    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    a_in     = 8'h00;
    b_in     = 8'h00;
    carry_in = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum",  {24'd0, sum_out}, 32'd0);
    chk("rst_cout", {31'd0, carry_out}, 32'd0);
    reset = 1'b0;
    tick();

    run_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    check_idle("zero");
    run_op("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    check_idle("ff_01");

    // Second operation issued in the DONE cycle of the first.
    run_op("a5_5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
    run_op("b2b_3c_0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0);
    check_idle("b2b");

    run_op("ignore_start", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b1);
    check_idle("ignore_start");

    // Abort during RUN: outputs clear asynchronously, no done follows.
    start    = 1'b1;
    a_in     = 8'h12;
    b_in     = 8'h34;
    carry_in = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_abort_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_sum",  {24'd0, sum_out}, 32'd0);
    chk("abort_cout", {31'd0, carry_out}, 32'd0);
    tick();
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    run_op("80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0);
    check_idle("80_80");

    for (int i = 0; i < 200; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rc   = 1'($urandom);
      rexp = 9'(ra) + 9'(rb) + 9'(rc);
      run_op("rand", ra, rb, rc, rexp[W-1:0], rexp[W], 1'b0);
      if ((i % 2) == 1) check_idle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_adder
